fixdiv: RTL and testbench

FIXDIV -- requirements
Module: fixdiv

---
 rtl/fixdiv.sv | 132 +++++++++++++
 tb/tb_fixdiv.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fixdiv.sv
// rtl/fixdiv.sv - signed fixed-point divider, restoring, round-half-even
module fixdiv #(
   parameter int WIDTH = 8,
   parameter int FBITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             valid,
   output logic             ovf,
   output logic             dbz,
   output logic [WIDTH-1:0] val
);

   localparam int N  = WIDTH + FBITS + 1;
   localparam int CW = $clog2(N);
   localparam logic [N-1:0] NEG_LIM = {{(N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [N-1:0] POS_LIM = NEG_LIM - 1'b1;

   typedef enum logic [1:0] {IDLE, CALC, ROUND, SIGN} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem;
   logic [N-1:0]     dq;
   logic [WIDTH-1:0] bmag;
   logic             sign;
   logic [N-1:0]     m;

   logic [WIDTH-1:0] a_mag, b_mag, m_low;
   logic [WIDTH:0]   rem_sh, rem_nxt;
   logic             q_bit, guard, sticky, ovf_c;
   logic [N-1:0]     m_trunc, m_rnd;

   // dq starts as the shifted dividend and fills with quotient bits from the right
   always_comb begin
      a_mag   = a[WIDTH-1] ? -a : a;
      b_mag   = b[WIDTH-1] ? -b : b;
      rem_sh  = {rem[WIDTH-1:0], dq[N-1]};
      q_bit   = (rem_sh >= {1'b0, bmag});
      rem_nxt = q_bit ? (rem_sh - {1'b0, bmag}) : rem_sh;
      guard   = dq[0];
      sticky  = |rem;
      m_trunc = dq >> 1;
      m_rnd   = m_trunc + {{(N-1){1'b0}}, guard & (sticky | m_trunc[0])};
      ovf_c   = sign ? (m > NEG_LIM) : (m > POS_LIM);
      m_low   = m[WIDTH-1:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && (b != '0)) state_nxt = CALC;
         CALC:    if (cnt == CW'(N-1)) state_nxt = ROUND;
         ROUND:   state_nxt = SIGN;
         SIGN:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         valid <= 1'b0;
         ovf   <= 1'b0;
         dbz   <= 1'b0;
         val   <= '0;
         cnt   <= '0;
         rem   <= '0;
         dq    <= '0;
         bmag  <= '0;
         sign  <= 1'b0;
         m     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (b != '0) begin
                     sign  <= a[WIDTH-1] ^ b[WIDTH-1];
                     bmag  <= b_mag;
                     dq    <= {a_mag, {(FBITS+1){1'b0}}};
                     rem   <= '0;
                     cnt   <= '0;
                     busy  <= 1'b1;
                     valid <= 1'b0;
                     ovf   <= 1'b0;
                     dbz   <= 1'b0;
                  end else begin
                     done  <= 1'b1;
                     dbz   <= 1'b1;
                     valid <= 1'b0;
                     ovf   <= 1'b0;
                     val   <= '0;
                  end
               end
            end
            CALC: begin
               rem <= rem_nxt;
               dq  <= {dq[N-2:0], q_bit};
               cnt <= cnt + 1'b1;
            end
            ROUND: m <= m_rnd;
            SIGN: begin
               done <= 1'b1;
               busy <= 1'b0;
               if (ovf_c) begin
                  ovf   <= 1'b1;
                  valid <= 1'b0;
                  val   <= '0;
               end else begin
                  ovf   <= 1'b0;
                  valid <= 1'b1;
                  val   <= sign ? -m_low : m_low;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fixdiv.sv
// tb/tb_fixdiv.sv - directed-vector bench for fixdiv (WIDTH=8, FBITS=4)
module tb_fixdiv;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [7:0] a, b, val;
   logic       busy, done, valid, ovf, dbz;

   int n_checks = 0;
   int n_fail   = 0;

   fixdiv #(.WIDTH(8), .FBITS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .valid(valid), .ovf(ovf), .dbz(dbz), .val(val)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_div(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ev, input logic evalid, input logic eovf);
      int cyc;
      a = av; b = bv; start = 1'b1;
      tick();
      start = 1'b0;
      a = ~av; b = 8'h00;
      check({tag, " busy"}, 32'(busy), 32'd1);
      cyc = 0;
      while (cyc < 40) begin
         tick();
         cyc++;
         if (done) break;
      end
      check({tag, " latency"}, 32'(cyc), 32'd15);
      check({tag, " val"}, 32'(val), 32'(ev));
      check({tag, " valid"}, 32'(valid), 32'(evalid));
      check({tag, " ovf"}, 32'(ovf), 32'(eovf));
      check({tag, " dbz"}, 32'(dbz), 32'd0);
      check({tag, " busy end"}, 32'(busy), 32'd0);
      tick();
      check({tag, " done pulse"}, 32'(done), 32'd0);
      check({tag, " val hold"}, 32'(val), 32'(ev));
   endtask

   initial begin
      int dones;
      rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
      tick(); tick();
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset valid", 32'(valid), 32'd0);
      check("reset ovf", 32'(ovf), 32'd0);
      check("reset dbz", 32'(dbz), 32'd0);
      check("reset val", 32'(val), 32'd0);
      rst = 1'b0;
      tick();

      run_div("3/2",      8'h30, 8'h20, 8'h18, 1'b1, 1'b0);
      run_div("-3/2",     8'hD0, 8'h20, 8'hE8, 1'b1, 1'b0);
      run_div("3/-2",     8'h30, 8'hE0, 8'hE8, 1'b1, 1'b0);
      run_div("-3/-2",    8'hD0, 8'hE0, 8'h18, 1'b1, 1'b0);
      run_div("tie even", 8'h01, 8'h20, 8'h00, 1'b1, 1'b0);
      run_div("tie up",   8'h03, 8'h20, 8'h02, 1'b1, 1'b0);
      run_div("1/3",      8'h10, 8'h30, 8'h05, 1'b1, 1'b0);
      run_div("1/6",      8'h10, 8'h60, 8'h03, 1'b1, 1'b0);
      run_div("min/1",    8'h80, 8'h10, 8'h80, 1'b1, 1'b0);
      run_div("min/-1",   8'h80, 8'hF0, 8'h00, 1'b0, 1'b1);
      run_div("big/lsb",  8'h70, 8'h01, 8'h00, 1'b0, 1'b1);
      run_div("zero/x",   8'h00, 8'hE0, 8'h00, 1'b1, 1'b0);

      // divide by zero
      a = 8'h30; b = 8'h00; start = 1'b1;
      tick();
      start = 1'b0;
      check("dbz done", 32'(done), 32'd1);
      check("dbz flag", 32'(dbz), 32'd1);
      check("dbz valid", 32'(valid), 32'd0);
      check("dbz ovf", 32'(ovf), 32'd0);
      check("dbz val", 32'(val), 32'd0);
      check("dbz busy", 32'(busy), 32'd0);
      tick();
      check("dbz done pulse", 32'(done), 32'd0);
      check("dbz busy after", 32'(busy), 32'd0);
      check("dbz hold", 32'(dbz), 32'd1);
      run_div("after dbz", 8'h30, 8'h20, 8'h18, 1'b1, 1'b0);

      // reset mid-calculation
      a = 8'h30; b = 8'h20; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      check("midrst valid", 32'(valid), 32'd0);
      check("midrst val", 32'(val), 32'd0);
      dones = 0;
      repeat (20) begin
         tick();
         if (done) dones++;
      end
      check("midrst no done", 32'(dones), 32'd0);

      // start while busy is ignored
      a = 8'h30; b = 8'h20; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      a = 8'h10; b = 8'h60; start = 1'b1;
      tick();
      start = 1'b0;
      dones = 0;
      repeat (25) begin
         tick();
         if (done) dones++;
      end
      check("busy start dones", 32'(dones), 32'd1);
      check("busy start val", 32'(val), 32'h18);
      check("busy start valid", 32'(valid), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
